// File: rtl/seq_gen_pkg.sv
// ============================================================================
// Module   : seq_gen_pkg
// Desc     : Shared types and constants for the seq_gen symbol sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_gen_pkg;

    typedef logic [1:0] sym_t;

    localparam sym_t IDLE_SYM_DEFAULT = 2'b00;

    // GAP exists only when inter-repetition gaps are compiled in
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
`ifdef SEQ_GEN_GAP_EN
        S_GAP  = 2'd3,
`endif
        S_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_gen_if.sv
// ============================================================================
// Module   : seq_gen_if
// Desc     : Control/pattern/symbol bundle for seq_gen (SEQ_GEN_GAP_EN adds gap_len).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_gen_if #(
    parameter int MAX_LEN = 8
);
    import seq_gen_pkg::*;

    localparam int LW = $clog2(MAX_LEN);

    logic                   load;
    logic [2*MAX_LEN-1:0]   load_data;
    logic [LW-1:0]          load_len;
    logic                   start;
    logic [3:0]             repeat_cnt;
`ifdef SEQ_GEN_GAP_EN
    logic [2:0]             gap_len;
`endif
    logic                   A;
    logic                   B;
    logic                   valid;
    logic                   busy;
    logic                   done;

    modport master (
`ifdef SEQ_GEN_GAP_EN
        output gap_len,
`endif
        output load, load_data, load_len, start, repeat_cnt,
        input  A, B, valid, busy, done
    );

    modport slave (
`ifdef SEQ_GEN_GAP_EN
        input  gap_len,
`endif
        input  load, load_data, load_len, start, repeat_cnt,
        output A, B, valid, busy, done
    );

endinterface

`default_nettype wire

// File: rtl/seq_gen.sv
// ============================================================================
// Module   : seq_gen
// Desc     : Two-wire pattern sequencer; replays a loaded symbol pattern N times.
//            Define SEQ_GEN_GAP_EN to insert idle gaps between repetitions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_gen
    import seq_gen_pkg::*;
#(
    parameter int   MAX_LEN  = 8,
    parameter sym_t IDLE_SYM = IDLE_SYM_DEFAULT
) (
    input  wire logic   clk,
    input  wire logic   clr,
    seq_gen_if.slave    bus
);

    localparam int LW = $clog2(MAX_LEN);

    state_t                 state_q,   state_d;
    logic [2*MAX_LEN-1:0]   pattern_q, pattern_d;
    logic [LW-1:0]          len_q,     len_d;
    logic [LW-1:0]          idx_q,     idx_d;
    logic [3:0]             rep_q,     rep_d;
    sym_t                   sym_q,     sym_d;
    logic                   valid_q,   valid_d;
    logic                   busy_q,    busy_d;
    logic                   done_q,    done_d;
`ifdef SEQ_GEN_GAP_EN
    logic [2:0]             gap_cfg_q, gap_cfg_d;
    logic [2:0]             gap_cnt_q, gap_cnt_d;
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= S_IDLE;
            pattern_q <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            rep_q     <= '0;
            sym_q     <= IDLE_SYM;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SEQ_GEN_GAP_EN
            gap_cfg_q <= '0;
            gap_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            rep_q     <= rep_d;
            sym_q     <= sym_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef SEQ_GEN_GAP_EN
            gap_cfg_q <= gap_cfg_d;
            gap_cnt_q <= gap_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        idx_d     = idx_q;
        rep_d     = rep_q;
        sym_d     = IDLE_SYM;
        valid_d   = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
`ifdef SEQ_GEN_GAP_EN
        gap_cfg_d = gap_cfg_q;
        gap_cnt_d = gap_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                // load takes priority so a same-cycle start never uses a half-updated pattern
                if (bus.load) begin
                    pattern_d = bus.load_data;
                    len_d     = bus.load_len;
                end else if (bus.start) begin
                    state_d = S_SEND;
                    idx_d   = '0;
                    rep_d   = (bus.repeat_cnt == 4'd0) ? 4'd1 : bus.repeat_cnt;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
`ifdef SEQ_GEN_GAP_EN
                    gap_cfg_d = bus.gap_len;
`endif
                end
            end

            S_SEND: begin
                if (idx_q != len_q) begin
                    idx_d   = idx_q + 1'b1;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else if (rep_q > 4'd1) begin
                    rep_d  = rep_q - 4'd1;
                    idx_d  = '0;
                    busy_d = 1'b1;
`ifdef SEQ_GEN_GAP_EN
                    if (gap_cfg_q != 3'd0) begin
                        state_d   = S_GAP;
                        gap_cnt_d = gap_cfg_q;
                    end else begin
                        valid_d = 1'b1;
                    end
`else
                    valid_d = 1'b1;
`endif
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    rep_d   = '0;
                    idx_d   = '0;
                end
            end

`ifdef SEQ_GEN_GAP_EN
            S_GAP: begin
                busy_d = 1'b1;
                if (gap_cnt_q <= 3'd1) begin
                    state_d   = S_SEND;
                    gap_cnt_d = '0;
                    valid_d   = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - 3'd1;
                end
            end
`endif

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Symbol mux keyed by the index that will be current after this edge
        if (valid_d) begin
            sym_d = pattern_q[{idx_d, 1'b0} +: 2];
        end
    end

    assign bus.A     = sym_q[1];
    assign bus.B     = sym_q[0];
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_gen.sv
// ============================================================================
// Module   : tb_seq_gen
// Desc     : Scoreboard bench for seq_gen; gap scenario runs when SEQ_GEN_GAP_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_gen;
    import seq_gen_pkg::*;

    localparam int MAX_LEN = 8;

    typedef struct {
        int busy;
        int gap;
    } txn_t;

    logic clk = 1'b0;
    logic clr = 1'b1;

    always #5 clk = ~clk;

    seq_gen_if #(.MAX_LEN(MAX_LEN)) bus ();

    seq_gen #(
        .MAX_LEN  (MAX_LEN),
        .IDLE_SYM (2'b00)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    logic [1:0] sym_q[$];
    txn_t       txn_q[$];
    int         n_checks   = 0;
    int         n_pass     = 0;
    int         done_seen  = 0;
    int         busy_run   = 0;
    int         gap_run    = 0;
    logic       prev_valid = 1'b0;
    logic       prev_done  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic push_pattern(input logic [1:0] s0, input logic [1:0] s1,
                                input logic [1:0] s2, input logic [1:0] s3, input int reps);
        for (int r = 0; r < reps; r++) begin
            sym_q.push_back(s0);
            sym_q.push_back(s1);
            sym_q.push_back(s2);
            sym_q.push_back(s3);
        end
    endtask

    task automatic do_load(input logic [15:0] data, input logic [2:0] len);
        @(negedge clk);
        bus.load      = 1'b1;
        bus.load_data = data;
        bus.load_len  = len;
        @(negedge clk);
        bus.load      = 1'b0;
    endtask

    task automatic do_start(input logic [3:0] rep);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.repeat_cnt = rep;
        @(negedge clk);
        bus.start      = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int  base;
        bit  seen;
        base = done_seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            #1;
            if (done_seen > base) seen = 1'b1;
        end
        check("done_within_budget", int'(seen), 1);
    endtask

    // Monitor: pops expected symbols on valid, expected transaction shape on done
    initial begin
        txn_t t;
        logic [1:0] e;
        forever begin
            @(negedge clk);
            if (!clr) begin
                busy_run   = 0;
                gap_run    = 0;
                prev_valid = 1'b0;
                prev_done  = 1'b0;
            end else begin
                if (bus.valid) begin
                    busy_run++;
                    check("busy_with_valid", int'(bus.busy), 1);
                    if (sym_q.size() == 0) begin
                        check("unexpected_valid", int'(bus.valid), 0);
                    end else begin
                        e = sym_q.pop_front();
                        check("symbol", int'({bus.A, bus.B}), int'(e));
                    end
                end else if (bus.busy) begin
                    busy_run++;
                    gap_run++;
                end
                if (bus.done) begin
                    check("done_after_last_symbol", int'(prev_valid), 1);
                    check("done_single_cycle", int'(prev_done), 0);
                    check("done_outputs_idle", int'({bus.A, bus.B, bus.valid, bus.busy}), 0);
                    if (txn_q.size() == 0) begin
                        check("unexpected_done", int'(bus.done), 0);
                    end else begin
                        t = txn_q.pop_front();
                        check("busy_cycles", busy_run, t.busy);
                        check("gap_cycles", gap_run, t.gap);
                    end
                    busy_run = 0;
                    gap_run  = 0;
                    done_seen++;
                end
                prev_valid = bus.valid;
                prev_done  = bus.done;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int saved_done;
        bus.load       = 1'b0;
        bus.load_data  = '0;
        bus.load_len   = '0;
        bus.start      = 1'b0;
        bus.repeat_cnt = '0;
`ifdef SEQ_GEN_GAP_EN
        bus.gap_len    = '0;
`endif

        // Reset state, checked before any clock edge while clr is held
        #2 clr = 1'b0;
        #1 check("reset_outputs", int'({bus.A, bus.B, bus.valid, bus.busy, bus.done}), 0);
        repeat (2) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        #1 check("idle_after_reset", int'({bus.A, bus.B, bus.valid, bus.busy, bus.done}), 0);

        // Basic: 00,01,11,10 twice, busy for 8 cycles
        do_load(16'h00B4, 3'd3);
        push_pattern(2'b00, 2'b01, 2'b11, 2'b10, 2);
        txn_q.push_back('{busy: 8, gap: 0});
        do_start(4'd2);
        wait_done(40);
        @(negedge clk);
        #1 check("idle_after_done", int'({bus.valid, bus.busy, bus.done}), 0);

        // Zero repeat count, single-symbol pattern
        do_load(16'h0003, 3'd0);
        sym_q.push_back(2'b11);
        txn_q.push_back('{busy: 1, gap: 0});
        do_start(4'd0);
        wait_done(20);

        // load and start together: load wins, nothing transmitted
        @(negedge clk);
        bus.load       = 1'b1;
        bus.start      = 1'b1;
        bus.load_data  = 16'h001B;
        bus.load_len   = 3'd3;
        bus.repeat_cnt = 4'd1;
        @(negedge clk);
        bus.load  = 1'b0;
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        #1 check("load_start_no_tx", int'(bus.busy), 0);

        // New pattern took effect; mid-send start/load are ignored
        push_pattern(2'b11, 2'b10, 2'b01, 2'b00, 1);
        txn_q.push_back('{busy: 4, gap: 0});
        do_start(4'd1);
        bus.start      = 1'b1;
        bus.load       = 1'b1;
        bus.load_data  = 16'hFFFF;
        bus.load_len   = 3'd0;
        bus.repeat_cnt = 4'd5;
        @(negedge clk);
        bus.start = 1'b0;
        bus.load  = 1'b0;
        wait_done(30);

        push_pattern(2'b11, 2'b10, 2'b01, 2'b00, 1);
        txn_q.push_back('{busy: 4, gap: 0});
        do_start(4'd1);
        wait_done(30);

        // Reset on the third symbol aborts without done
        do_load(16'h00B4, 3'd3);
        push_pattern(2'b00, 2'b01, 2'b11, 2'b10, 2);
        txn_q.push_back('{busy: 8, gap: 0});
        do_start(4'd2);
        @(posedge clk);
        @(posedge clk);
        #7;
        saved_done = done_seen;
        check("symbols_before_abort", sym_q.size(), 5);
        clr = 1'b0;
        #1 check("abort_outputs_idle", int'({bus.A, bus.B, bus.valid, bus.busy, bus.done}), 0);
        sym_q.delete();
        txn_q.delete();
        repeat (2) @(negedge clk);
        clr = 1'b1;
        repeat (3) @(negedge clk);
        #1 check("no_done_after_abort", done_seen, saved_done);

        sym_q.push_back(2'b00);
        txn_q.push_back('{busy: 1, gap: 0});
        do_start(4'd1);
        wait_done(20);

`ifdef SEQ_GEN_GAP_EN
        // Two idle busy cycles between repetitions
        do_load(16'h00B4, 3'd3);
        push_pattern(2'b00, 2'b01, 2'b11, 2'b10, 2);
        txn_q.push_back('{busy: 10, gap: 2});
        bus.gap_len = 3'd2;
        do_start(4'd2);
        wait_done(40);
        bus.gap_len = 3'd0;
`endif

        repeat (3) @(negedge clk);
        check("symbols_all_consumed", sym_q.size(), 0);
        check("txns_all_consumed", txn_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 Parameter MAX_LEN, default 8: maximum symbols per pattern (2..16).
REQ-003 Parameter IDLE_SYM, default 2'b00: symbol driven on {A,B} when not sending.
REQ-004 Port clk, input, 1 bit: rising-edge clock.
REQ-005 Port clr, input, 1 bit: asynchronous active-low reset.
REQ-006 Port load, input, 1 bit: latch the pattern; honoured only in IDLE.
REQ-007 Port load_data, input, 2*MAX_LEN bits: the symbols, with symbol i at bits [2i+1:2i].
REQ-008 Port load_len, input, $clog2(MAX_LEN) bits: pattern length minus 1.
REQ-009 Port start, input, 1 bit: begin transmission; honoured only in IDLE.
REQ-010 Port repeat_cnt, input, 4 bits: pattern repetitions; 0 is treated as 1; sampled with start.
REQ-011 Port A, output, 1 bit: symbol bit 1 (registered).
REQ-012 Port B, output, 1 bit: symbol bit 0 (registered).
REQ-013 Port valid, output, 1 bit: {A,B} carries a pattern symbol this cycle.
REQ-014 Port busy, output, 1 bit: transmission in progress, from start acceptance through the last symbol.
REQ-015 Port done, output, 1 bit: one-cycle pulse after the final symbol.

Function
REQ-016 SHALL implement an FSM with states IDLE, SEND, GAP (macro only) and DONE; all outputs SHALL be registered.
REQ-017 IDLE: {A,B}=IDLE_SYM, valid=0, busy=0, done=0.
REQ-018 IDLE with load=1: pattern and length registers update at the edge.
REQ-019 IDLE with load=1 and start=1 in the same cycle: load SHALL win and start SHALL be ignored.
REQ-020 IDLE with start=1 sampled at edge N:
- From edge N: state=SEND, idx=0, symbol 0 on {A,B}, valid=1, busy=1.
- Latency from start to first symbol is therefore one edge.
REQ-021 SEND: each edge advances idx by one and outputs the next symbol.
REQ-022 SEND, idx wrap-around:
- Condition: idx==load_len and repetitions remain.
- The next edge SHALL set idx=0 and output symbol 0 with no bubble, or enter GAP per REQ-031.
REQ-023 SEND, final symbol of final repetition: the next edge SHALL enter DONE with done=1, valid=0, busy=0 and {A,B}=IDLE_SYM.
REQ-024 DONE SHALL last exactly one cycle, then return to IDLE.
REQ-025 Total valid cycles SHALL equal (load_len+1) * max(repeat_cnt,1).
REQ-026 load and start SHALL be ignored while busy=1 or in DONE; pattern registers SHALL be stable during transmission.
REQ-027 A pattern of length 1 (load_len=0) SHALL emit one symbol per repetition.

Reset
REQ-028 clr=0 SHALL immediately, independent of clk, set:
- state=IDLE
- pattern=0, length=0, idx=0, repeat counter=0
- {A,B}=IDLE_SYM, valid=0, busy=0, done=0
REQ-029 Reset during SEND or GAP SHALL abort without a done pulse; the first edge after release with start=1 SHALL behave per REQ-020 using the reset pattern (all symbols 00, length 1) unless reloaded.

Configuration
REQ-030 Macro SEQ_GEN_GAP_EN SHALL add input gap_len (3 bits) and state GAP; gap_len is sampled with start.
REQ-031 With SEQ_GEN_GAP_EN defined and gap_len=G>0, GAP SHALL be entered between repetitions (never after the last one):
- Lasts G cycles with {A,B}=IDLE_SYM, valid=0, busy=1.
- Then returns to SEND with symbol 0.
- G=0 SHALL behave as back-to-back.
REQ-032 Without SEQ_GEN_GAP_EN: no gap_len port, no GAP state, repetitions always back-to-back.

Structure
REQ-033 Package seq_gen_pkg SHALL hold:
- the state enum
- the 2-bit symbol typedef
- the IDLE_SYM default constant
REQ-034 A single module; no sub-module (the symbol mux, idx counter and repeat counter are inline).

Verification
REQ-035 Basic: load_data=16'h00B4, load_len=3, start, repeat_cnt=2 -> {A,B}=00,01,11,10,00,01,11,10 on 8 consecutive valid cycles, done on the 9th cycle, busy high exactly for those 8 cycles.
REQ-036 Zero repeat count: repeat_cnt=0, load_len=0, load_data[1:0]=2'b11 -> one valid cycle {A,B}=11, then done.
REQ-037 Ignored inputs: load and start asserted together in IDLE -> no transmission; start pulsed mid-SEND -> sequence length unchanged.
REQ-038 Reset mid-operation: clr=0 on the 3rd symbol of REQ-035 -> outputs idle immediately, done never pulses, and the next start emits a single 00 symbol.
REQ-039 With SEQ_GEN_GAP_EN: REQ-035 stimulus with gap_len=2 -> 4 symbols, 2 idle cycles (busy=1, valid=0), 4 symbols, then done.
